// File: rtl/cache_line_writeback.sv
// Cache write-back path: captures a dirty victim line in one cycle and
// streams it to memory one word per acknowledged beat.
module cache_line_writeback #(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int LINE_BITS      = $clog2(WORDS_PER_LINE),
  parameter int BYTE_BITS      = 2
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                start,
  input  logic [31:0]                         line_addr,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_data,
  input  logic                                mem_ack,
  output logic                                mem_we,
  output logic [31:0]                         mem_addr,
  output logic [WORD_SIZE-1:0]                mem_data,
  output logic                                busy,
  output logic                                done
);

  localparam int N   = WORDS_PER_LINE;
  localparam int OFF = LINE_BITS + BYTE_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                 state_q;
  logic [LINE_BITS-1:0]   cnt_q;
  logic [LINE_BITS-1:0]   cnt_d;
  logic [31:0]            base_q;
  logic [31:0]            base_d;
  logic [31:0]            addr_d;
  logic                   last;
  logic [WORD_SIZE-1:0]   buf_q [N];

  assign cnt_d  = cnt_q + LINE_BITS'(1);
  assign last   = (cnt_q == LINE_BITS'(N - 1));
  assign base_d = {line_addr[31:OFF], {OFF{1'b0}}};
  // Offset stays inside the line, so the add never carries past base.
  assign addr_d = base_q + 32'({cnt_d, {BYTE_BITS{1'b0}}});

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= line_data[WORD_SIZE*i +: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= WRITE;
            cnt_q    <= '0;
            base_q   <= base_d;
            mem_we   <= 1'b1;
            busy     <= 1'b1;
            mem_addr <= base_d;
            mem_data <= line_data[WORD_SIZE-1:0];
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (last) begin
              state_q  <= DONE;
              cnt_q    <= '0;
              mem_we   <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              mem_addr <= '0;
              mem_data <= '0;
            end else begin
              cnt_q    <= cnt_d;
              mem_addr <= addr_d;
              mem_data <= buf_q[cnt_d];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_writeback.sv
// Scoreboard bench for cache_line_writeback: expected beats are queued
// when a line is started and retired as the memory accepts them.
module tb_cache_line_writeback;

  localparam int N  = 8;
  localparam int WS = 32;

  logic            clk;
  logic            clr;
  logic            start;
  logic [31:0]     line_addr;
  logic [WS*N-1:0] line_data;
  logic            mem_ack;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [WS-1:0]   mem_data;
  logic            busy;
  logic            done;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    errors  = 0;

  cache_line_writeback dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .line_addr (line_addr),
    .line_data (line_data),
    .mem_ack   (mem_ack),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write beat must match the head of the queue, stalled or not.
  always @(negedge clk) begin
    if (!clr && mem_we) begin
      if (sb.size() == 0) begin
        chk("extra_write", 32'(mem_we), 32'd0);
      end else begin
        chk("addr", mem_addr, sb[0].a);
        chk("data", mem_data, sb[0].d);
        if (mem_ack) void'(sb.pop_front());
      end
    end
  end

  task automatic begin_line(input logic [31:0] a, input logic [WS*N-1:0] d);
    logic [31:0] base;
    base = {a[31:5], 5'b0};
    for (int i = 0; i < N; i++) begin
      sb.push_back('{a: base + 32'(i * 4), d: d[WS*i +: WS]});
    end
    start     = 1'b1;
    line_addr = a;
    line_data = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_we", 32'(mem_we), 32'd1);
  endtask

  task automatic run_xfer(input int stall_word, input int stall_len,
                          input bit inj, input int abort_at,
                          output int cyc);
    int wc;
    int st;
    bit acc;
    wc  = 0;
    st  = 0;
    cyc = 0;
    while (cyc < 100) begin
      if (wc == stall_word && st < stall_len) begin
        mem_ack = 1'b0;
        st++;
      end else begin
        mem_ack = 1'b1;
      end
      acc = mem_we && mem_ack;
      if (inj && cyc == 3) begin
        start     = 1'b1;
        line_addr = 32'h5555_0000;
        line_data = {N{32'hDEAD_BEEF}};
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) wc++;
      if (abort_at > 0 && wc == abort_at) begin
        clr = 1'b1;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        #1;
        clr     = 1'b0;
        mem_ack = 1'b0;
        sb.delete();
        return;
      end
      if (done) break;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    if (cyc >= 100) chk("timeout", 32'(cyc), 32'd0);
  endtask

  task automatic end_line(input string tag, input int cyc, input int exp);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [WS*N-1:0] rand_line();
    logic [WS*N-1:0] d;
    for (int i = 0; i < N; i++) d[WS*i +: WS] = $urandom;
    return d;
  endfunction

  initial begin
    int              cyc;
    logic [WS*N-1:0] d;

    clr       = 1'b1;
    start     = 1'b0;
    line_addr = '0;
    line_data = '0;
    mem_ack   = 1'b0;
    #12;
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while idle
    #2;
    clr = 1'b1;
    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back acknowledges
    for (int i = 0; i < N; i++) d[WS*i +: WS] = 32'hA0 + 32'(i);
    begin_line(32'h0000_1234, d);
    run_xfer(-1, 0, 1'b0, 0, cyc);
    end_line("b2b", cyc, N);

    // Three-cycle stall on word 2
    begin_line(32'h0040_0088, rand_line());
    run_xfer(2, 3, 1'b0, 0, cyc);
    end_line("stall", cyc, N + 3);

    // Starts during WRITE and during DONE are ignored
    begin_line(32'h1000_0010, rand_line());
    run_xfer(-1, 0, 1'b1, 0, cyc);
    chk("ign_cycles", 32'(cyc), 32'(N));
    start     = 1'b1;
    line_addr = 32'h7777_0000;
    line_data = rand_line();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ign_we", 32'(mem_we), 32'd0);
      chk("ign_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("ign_drained", 32'(sb.size()), 32'd0);

    // Abort after word 4, then restart from word 0
    begin_line(32'h2000_0040, rand_line());
    run_xfer(-1, 0, 1'b0, 5, cyc);
    chk("abort_cycles", 32'(cyc), 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_idle_we", 32'(mem_we), 32'd0);
    end
    begin_line(32'h2000_0040, rand_line());
    run_xfer(-1, 0, 1'b0, 0, cyc);
    end_line("restart", cyc, N);

    // Line at the top of the address space
    begin_line(32'hFFFF_FFFC, rand_line());
    run_xfer(4, 1, 1'b0, 0, cyc);
    end_line("top", cyc, N + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
